cla_serial_controller: RTL
==========================

// Module: cla_serial_controller
// PURPOSE
//  Sequences one 8-bit carry-lookahead slice (cla8) to perform NBYTES-wide add/subtract byte-serially.
//  Carry is chained between bytes, LS byte first. Sum bytes are streamed out with a final carry/overflow flag.
//  Sits between an operand byte stream (from pins or a host FSM) and a result consumer, both with valid/ready.
// PARAMETERS
//  NBYTES  4  operand width in bytes (>=1); one operation = NBYTES accepted byte pairs
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  synchronous active-low reset
//  in_valid   in   1  a_byte/b_byte/op_sub valid
//  in_ready   out  1  controller accepts the byte pair this cycle
//  a_byte     in   8  operand A byte (LS byte first)
//  b_byte     in   8  operand B byte (LS byte first)
//  op_sub     in   1  1 = A-B, 0 = A+B; sampled only on byte 0, ignored on later bytes
//  out_valid  out  1  out_byte valid
//  out_ready  in   1  consumer accepts out_byte
//  out_byte   out  8  sum/difference byte
//  out_last   out  1  out_byte is byte NBYTES-1 of the operation
//  out_cout   out  1  final carry-out (sub: 1 = no borrow); valid only with out_last, else 0
//  out_ovf    out  1  signed overflow = carry into bit 7 XOR cout of last byte; valid only with out_last, else 0
//  busy       out  1  operation in progress (byte 0 accepted, last byte not yet accepted)
// BEHAVIOUR
//  Reset (rst_n low at clk edge): state=IDLE, idx=0, carry=0, sub=0; all outputs 0 except in_ready=1.
//  Handshake: transfer when valid&&ready, same edge. in_ready = !out_valid || out_ready (1-entry output reg).
//  Latency: byte pair accepted at edge N -> out_byte visible after edge N; full throughput, 1 byte/cycle.
//  FSM states:
//   IDLE: in_ready per rule; on accept -> sub<=op_sub, cin=op_sub, idx<=1, go RUN (or stay IDLE if NBYTES==1).
//   RUN : each accept uses cin=carry reg, idx<=idx+1; accept with idx==NBYTES-1 -> idx<=0, carry<=0, go IDLE.
//  Datapath per accepted pair: b_eff = sub ? ~b_byte : b_byte; {cout,sum} = cla8(a_byte, b_eff, cin).
//   carry<=cout; out_byte<=sum; out_last<=(idx==NBYTES-1); on last: out_cout<=cout, out_ovf<=c7^cout.
//  Output reg: loads on accept; out_valid clears when out_ready && no new accept same cycle.
//  op_sub on bytes 1..NBYTES-1 has no effect; no mixed add/sub within one operation.
//  Back-to-back ops: byte 0 of next op may be accepted the cycle after the last byte; carry starts fresh (0 or 1 for sub).
//  Backpressure: while out_valid && !out_ready, out_* held stable, in_ready=0, idx/carry frozen.
//  Reset mid-operation: partial op discarded, pending output dropped, next accepted pair is byte 0.
//  idx width = max(1,$clog2(NBYTES)); idx never exceeds NBYTES-1; wraps to 0 only on last accept.
// STRUCTURE
//  Shared package cla_pkg: state encoding (IDLE, RUN), BYTE_W=8 constant.
//  One sub-module: cla8 (a, b, cin -> sum[7:0], c7 (carry into bit 7), cout); pure combinational lookahead,
//   g=a&b, p=a|b, two-level carry equations; controller holds all state.
// TESTING (NBYTES=4, out_ready=1 unless stated)
//  1. add 0x000000FF + 0x00000001 -> out bytes 00,01,00,00; out_last on 4th; cout=0, ovf=0.
//  2. add 0xFFFFFFFF + 0x00000001 -> 00,00,00,00; cout=1, ovf=0; busy high bytes 0..3, low after.
//  3. add 0x7FFFFFFF + 0x00000001 -> 00,00,00,80; cout=0, ovf=1.
//  4. sub 0x00000005 - 0x00000007 (op_sub=1 on byte 0 only) -> FE,FF,FF,FF; cout=0 (borrow), ovf=0;
//     immediately followed by add 1+1 -> 02,00,00,00 proving carry reset between ops.
//  5. out_ready low 3 cycles after byte 1 -> in_ready=0, out_byte=byte1 held; resume -> no loss/duplication.
//  6. rst_n low for 1 cycle after byte 2 accepted -> outputs cleared; next stream 01..+01.. yields 02,00,00,00.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the byte-serial carry-lookahead add/subtract controller.
package cla_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One result beat as held in the output register
    typedef struct packed {
        logic              last;
        logic              cout;
        logic              ovf;
        logic [BYTE_W-1:0] data;
    } out_beat_t;

endpackage

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder slice: generate/propagate with flattened two-level carries.
module cla8
    import cla_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              c7,
    output logic              cout
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   c;
    logic              prop;

    // Each carry is a sum of products over g[j] and the p-run above it, no ripple
    always_comb begin
        g    = a & b;
        p    = a | b;
        c    = '0;
        prop = 1'b0;
        c[0] = cin;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            c[i+1] = g[i];
            prop   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & prop);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (cin & prop);
        end
    end

    assign sum  = (a ^ b) ^ c[BYTE_W-1:0];
    assign c7   = c[BYTE_W-1];
    assign cout = c[BYTE_W];

endmodule

// File: rtl/cla_serial_controller.sv
// Byte-serial NBYTES-wide add/subtract built around one cla8 slice, LS byte first,
// with valid/ready on both the operand stream and the result stream.
module cla_serial_controller
    import cla_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] a_byte,
    input  logic [BYTE_W-1:0] b_byte,
    input  logic              op_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_ovf,
    output logic              busy
);

    localparam int unsigned     IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic              carry;
    logic              carry_next;
    logic              sub;
    logic              sub_next;
    out_beat_t         beat;

    logic              accept;
    logic              is_last;
    logic              sub_eff;
    logic              cin;
    logic [BYTE_W-1:0] b_eff;
    logic [BYTE_W-1:0] sum;
    logic              c7;
    logic              cout;

    // Single-entry output register: refill allowed in the same cycle it drains
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_last  = (idx == LAST_IDX);

    // Byte 0 takes its mode and carry-in straight from the stream; later bytes use the latched ones
    assign sub_eff = (state == IDLE) ? op_sub : sub;
    assign cin     = (state == IDLE) ? op_sub : carry;
    assign b_eff   = sub_eff ? ~b_byte : b_byte;

    cla8 u_cla8 (
        .a    (a_byte),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .c7   (c7),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        carry_next = carry;
        sub_next   = sub;
        case (state)
            IDLE: begin
                if (accept) begin
                    sub_next = op_sub;
                    if (is_last) begin
                        idx_next   = '0;
                        carry_next = 1'b0;
                    end else begin
                        state_next = RUN;
                        idx_next   = IDX_W'(1);
                        carry_next = cout;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (is_last) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        carry_next = 1'b0;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        carry_next = cout;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                carry_next = 1'b0;
            end
        endcase
    end

    // Sequence counters and the result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            carry     <= 1'b0;
            sub       <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            beat      <= '0;
        end else begin
            idx   <= idx_next;
            carry <= carry_next;
            sub   <= sub_next;
            busy  <= (state_next == RUN);
            if (accept) begin
                out_valid <= 1'b1;
                beat      <= '{last: is_last,
                               cout: is_last & cout,
                               ovf:  is_last & (c7 ^ cout),
                               data: sum};
            end else if (out_ready) begin
                out_valid <= 1'b0;
                beat      <= '0;
            end
        end
    end

    assign out_byte = beat.data;
    assign out_last = beat.last;
    assign out_cout = beat.cout;
    assign out_ovf  = beat.ovf;

endmodule
